sram_read_responder: RTL and testbench
======================================

# sram_read_responder

AXI4 slave-side read responder sitting between the bridge's slave port (AR/R channels) and a single-port word SRAM. It accepts one read address at a time, walks the burst, fetches each word from the SRAM and returns it on R with the bridge-extended ID and RLAST. It completes the read path opposite the bridge's master-side read arbitration. Write channels are handled elsewhere.

## Interface
- ID_BITS, 8, slave-side ID width (master ID extended by bridge)
- ADDR_BITS, 32, AXI address width
- DATA_BITS, 32, AXI/SRAM data width
- LEN_BITS, 4, ARLEN width (1–16 beats)
- MEM_ADDR_BITS, 14, SRAM word-address width

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- ARID_S  in  ID_BITS  read ID
- ARADDR_S  in  ADDR_BITS  byte start address
- ARLEN_S  in  LEN_BITS  beats-1
- ARSIZE_S  in  3  ignored; transfers are always 4 bytes
- ARBURST_S  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- ARVALID_S  in  1  address valid
- ARREADY_S  out  1  address ready
- RID_S  out  ID_BITS  returned ID
- RDATA_S  out  DATA_BITS  read data
- RRESP_S  out  2  00 OKAY, 10 SLVERR
- RLAST_S  out  1  last beat
- RVALID_S  out  1  data valid
- RREADY_S  in  1  data ready
- mem_CS  out  1  SRAM chip select (SRAM samples mem_A on rising edge when high)
- mem_OE  out  1  SRAM output enable
- mem_A  out  MEM_ADDR_BITS  SRAM word address
- mem_DO  in  DATA_BITS  SRAM data; valid the cycle after a sampling edge, held until the next sampling edge

## Operation
- States: IDLE, ADDR, RESP.
- IDLE: ARREADY_S=1, R outputs inactive. ARVALID_S&ARREADY_S latches ID, ARADDR_S[MEM_ADDR_BITS+1:2] as word address, ARLEN_S, ARBURST_S; beat counter=0; -> ADDR.
- ADDR: ARREADY_S=0; mem_CS=1, mem_OE=1, mem_A=current word address; -> RESP unconditionally.
- RESP: mem_CS=0, mem_OE=1, mem_A held; RVALID_S=1, RDATA_S=mem_DO, RID_S=latched ID, RLAST_S=(counter==len), RRESP_S=SLVERR if burst==11 else OKAY.
  - RREADY_S=0: stay; all R outputs stable.
  - RREADY_S=1 and !RLAST_S: counter+1, advance address, -> ADDR.
  - RREADY_S=1 and RLAST_S: -> IDLE.
- Address advance (word units, MEM_ADDR_BITS modulo): FIXED and reserved: unchanged. INCR: +1, wraps at 2^MEM_ADDR_BITS. WRAP: +1 within aligned block of len+1 words; low log2(len+1) bits wrap, upper bits fixed. WRAP with len not in {1,3,7,15} is treated as INCR.
- Upper ARADDR_S bits above MEM_ADDR_BITS+2 and bits [1:0] ignored (decode done by bridge).
- Outside RESP: RVALID_S=0, RLAST_S=0, RDATA_S=0, RRESP_S=00; RID_S holds last latched ID.
- Outside ADDR: mem_CS=0.

## Timing
- Reset (reset low at a rising edge): next cycle state IDLE, ARREADY_S=1, RVALID_S=0, RLAST_S=0, RDATA_S=0, RRESP_S=00, RID_S=0, mem_CS=0, mem_OE=0, mem_A=0, counter=0.
- Reset mid-burst: burst abandoned at that edge; no further beats; RVALID_S low the following cycle.
- Latency: AR handshake at edge N -> ADDR in cycle N+1 -> RVALID_S high in cycle N+2.
- Throughput with RREADY_S held high: one beat per 2 cycles; n-beat burst occupies 2n cycles after the handshake; ARREADY_S high again the cycle after the last beat's handshake.
- ARVALID_S in the same cycle as the final R handshake is not accepted (ARREADY_S=0); it is accepted the next cycle.
- RDATA_S must not change while RVALID_S=1 and RREADY_S=0 (relies on SRAM hold; mem_CS low in RESP).

## Test plan
- Single read: SRAM[0x10]=0xDEADBEEF; AR ID=0x12, ADDR=0x40, LEN=0, INCR, RREADY=1 -> RVALID two cycles after handshake, RDATA=0xDEADBEEF, RID=0x12, RLAST=1, RRESP=00; ARREADY high the next cycle.
- INCR burst with backpressure: ADDR=0x100, LEN=3, SRAM[0x40..0x43]=1,2,3,4; RREADY low 3 cycles on beat 2 -> data 1,2,3,4 in order, beat 2 stable while stalled, RLAST only on beat 4.
- WRAP: ADDR=0x18 (word 6), LEN=3 -> words 6,7,4,5; FIXED LEN=2 at word 9 -> word 9 three times.
- Reserved burst 11, LEN=1 -> two beats, RRESP=10 on both, address unchanged.
- INCR wrap-around: word 0x3FFF, LEN=1 -> words 0x3FFF then 0x0000.
- Reset asserted during beat 2 of LEN=7 burst -> RVALID=0 next cycle, ARREADY=1, new AR accepted and served correctly.

Source files
------------

// File: rtl/sram_read_responder_if.sv
// Purpose: AXI4 read-address and read-data channels between the bridge slave port and the SRAM read responder.
// Latency: none; this is wiring only.
// Backpressure: AR is valid/ready, R is valid/ready; the slave modport owns ARREADY_S and the R outputs.
// Ports: AR channel (ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, ARREADY_S),
//        R channel (RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S, RREADY_S).
interface sram_read_responder_if #(
    parameter int ID_BITS   = 8,
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 4
);
    logic [ID_BITS-1:0]   ARID_S;
    logic [ADDR_BITS-1:0] ARADDR_S;
    logic [LEN_BITS-1:0]  ARLEN_S;
    logic [2:0]           ARSIZE_S;
    logic [1:0]           ARBURST_S;
    logic                 ARVALID_S;
    logic                 ARREADY_S;

    logic [ID_BITS-1:0]   RID_S;
    logic [DATA_BITS-1:0] RDATA_S;
    logic [1:0]           RRESP_S;
    logic                 RLAST_S;
    logic                 RVALID_S;
    logic                 RREADY_S;

    modport slave (
        input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        output ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );

    modport master (
        output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S, RREADY_S,
        input  ARREADY_S, RID_S, RDATA_S, RRESP_S, RLAST_S, RVALID_S
    );
endinterface

// File: rtl/sram_read_responder.sv
// Purpose: AXI4 slave read responder; walks one AR burst at a time and returns each SRAM word on R.
// Latency: AR handshake at edge N -> SRAM access in cycle N+1 -> RVALID_S in cycle N+2; one beat per 2 cycles.
// Backpressure: RREADY_S low holds the beat (SRAM output is held, mem_CS low); ARREADY_S only while idle.
// Ports: clock, reset (sync, active low); bus (slave modport: AR in, R out);
//        mem_CS/mem_OE/mem_A to the single-port SRAM, mem_DO from it.
module sram_read_responder #(
    parameter int ID_BITS       = 8,
    parameter int ADDR_BITS     = 32,
    parameter int DATA_BITS     = 32,
    parameter int LEN_BITS      = 4,
    parameter int MEM_ADDR_BITS = 14
) (
    input  logic                     clock,
    input  logic                     reset,
    sram_read_responder_if.slave     bus,
    output logic                     mem_CS,
    output logic                     mem_OE,
    output logic [MEM_ADDR_BITS-1:0] mem_A,
    input  logic [DATA_BITS-1:0]     mem_DO
);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;
    localparam logic [1:0] BURST_RSVD  = 2'b11;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [ID_BITS-1:0]       id_q, id_nxt;
    logic [MEM_ADDR_BITS-1:0] waddr_q, waddr_nxt;
    logic [LEN_BITS-1:0]      len_q, len_nxt;
    logic [1:0]               burst_q, burst_nxt;
    logic [LEN_BITS-1:0]      cnt_q, cnt_nxt;

    logic                     is_last;
    logic [LEN_BITS:0]        len_p1;
    logic                     wrap_ok;
    logic [MEM_ADDR_BITS-1:0] wrap_mask;
    logic [MEM_ADDR_BITS-1:0] addr_inc;
    logic [MEM_ADDR_BITS-1:0] addr_adv;

    // Address bits outside the SRAM word range are decoded by the bridge; ARSIZE is fixed at 4 bytes.
    logic unused_ar_bits;
    assign unused_ar_bits = ^{bus.ARSIZE_S, bus.ARADDR_S[ADDR_BITS-1:MEM_ADDR_BITS+2], bus.ARADDR_S[1:0]};

    assign is_last   = (cnt_q == len_q);
    assign len_p1    = {1'b0, len_q} + {{LEN_BITS{1'b0}}, 1'b1};
    // A wrap block must be 2, 4, 8 or 16 words; any other length degrades to INCR.
    assign wrap_ok   = (len_q != '0) && ((len_p1 & {1'b0, len_q}) == '0);
    assign wrap_mask = {{(MEM_ADDR_BITS-LEN_BITS){1'b0}}, len_q};
    assign addr_inc  = waddr_q + {{(MEM_ADDR_BITS-1){1'b0}}, 1'b1};

    always_comb begin
        addr_adv = waddr_q;
        case (burst_q)
            BURST_INCR: addr_adv = addr_inc;
            BURST_WRAP: begin
                if (wrap_ok) begin
                    // Low bits count within the aligned block, upper bits stay put.
                    addr_adv = (waddr_q & ~wrap_mask) | (addr_inc & wrap_mask);
                end else begin
                    addr_adv = addr_inc;
                end
            end
            default:    addr_adv = waddr_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            id_q    <= '0;
            waddr_q <= '0;
            len_q   <= '0;
            burst_q <= BURST_FIXED;
            cnt_q   <= '0;
        end else begin
            state   <= state_nxt;
            id_q    <= id_nxt;
            waddr_q <= waddr_nxt;
            len_q   <= len_nxt;
            burst_q <= burst_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        id_nxt        = id_q;
        waddr_nxt     = waddr_q;
        len_nxt       = len_q;
        burst_nxt     = burst_q;
        cnt_nxt       = cnt_q;

        bus.ARREADY_S = 1'b0;
        bus.RVALID_S  = 1'b0;
        bus.RLAST_S   = 1'b0;
        bus.RDATA_S   = '0;
        bus.RRESP_S   = RESP_OKAY;
        bus.RID_S     = id_q;
        mem_CS        = 1'b0;
        mem_OE        = 1'b0;
        mem_A         = waddr_q;

        case (state)
            IDLE: begin
                bus.ARREADY_S = 1'b1;
                if (bus.ARVALID_S) begin
                    id_nxt    = bus.ARID_S;
                    waddr_nxt = bus.ARADDR_S[MEM_ADDR_BITS+1:2];
                    len_nxt   = bus.ARLEN_S;
                    burst_nxt = bus.ARBURST_S;
                    cnt_nxt   = '0;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                mem_CS    = 1'b1;
                mem_OE    = 1'b1;
                state_nxt = RESP;
            end
            RESP: begin
                // mem_CS stays low so the SRAM keeps driving the same word during a stall.
                mem_OE       = 1'b1;
                bus.RVALID_S = 1'b1;
                bus.RDATA_S  = mem_DO;
                bus.RLAST_S  = is_last;
                bus.RRESP_S  = (burst_q == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
                if (bus.RREADY_S) begin
                    if (is_last) begin
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt   = cnt_q + {{(LEN_BITS-1){1'b0}}, 1'b1};
                        waddr_nxt = addr_adv;
                        state_nxt = ADDR;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sram_read_responder.sv
module tb_sram_read_responder;

    localparam int ID_BITS = 8;
    localparam int ADDR_BITS = 32;
    localparam int DATA_BITS = 32;
    localparam int LEN_BITS = 4;
    localparam int MEM_ADDR_BITS = 14;
    localparam int MEM_WORDS = 1 << MEM_ADDR_BITS;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic mem_CS, mem_OE;
    logic [MEM_ADDR_BITS-1:0] mem_A;
    logic [DATA_BITS-1:0] mem_DO = '0;

    sram_read_responder_if #(.ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS),
                             .DATA_BITS(DATA_BITS), .LEN_BITS(LEN_BITS)) bus ();

    sram_read_responder #(
        .ID_BITS(ID_BITS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
        .LEN_BITS(LEN_BITS), .MEM_ADDR_BITS(MEM_ADDR_BITS)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave),
        .mem_CS(mem_CS),
        .mem_OE(mem_OE),
        .mem_A (mem_A),
        .mem_DO(mem_DO)
    );

    always #5 clock = ~clock;

    // SRAM model: samples the address on a rising edge with CS high, holds the data until the next sample.
    logic [DATA_BITS-1:0] mem [0:MEM_WORDS-1];
    always @(posedge clock) if (mem_CS) mem_DO <= mem[mem_A];

    typedef struct packed {
        logic [ID_BITS-1:0]   id;
        logic [DATA_BITS-1:0] data;
        logic [1:0]           resp;
        logic                 last;
    } beat_t;

    beat_t exp_q[$];
    int tests = 0;
    int fails = 0;
    int beats_done = 0;
    int ncyc = 0;
    bit rand_ready = 0;
    int stall_at = -1;
    int stall_left = 0;
    bit finished = 0;

    // Reference model: list every word address of the burst from the AXI rules.
    task automatic push_model(input logic [ID_BITS-1:0] id, input logic [ADDR_BITS-1:0] addr,
                              input int len, input logic [1:0] burst);
        int w, blk, base;
        beat_t e;
        w = int'(addr[MEM_ADDR_BITS+1:2]);
        for (int b = 0; b <= len; b++) begin
            e.id   = id;
            e.data = mem[w];
            e.resp = (burst == 2'b11) ? 2'b10 : 2'b00;
            e.last = (b == len);
            exp_q.push_back(e);
            if (burst == 2'b01) begin
                w = (w + 1) % MEM_WORDS;
            end else if (burst == 2'b10) begin
                if (len == 1 || len == 3 || len == 7 || len == 15) begin
                    blk  = len + 1;
                    base = w - (w % blk);
                    w    = base + ((w - base + 1) % blk);
                end else begin
                    w = (w + 1) % MEM_WORDS;
                end
            end
        end
    endtask

    task automatic send_ar(input logic [ID_BITS-1:0] id, input logic [ADDR_BITS-1:0] addr,
                           input int len, input logic [1:0] burst);
        bit ok;
        push_model(id, addr, len, burst);
        @(posedge clock); #1;
        bus.ARID_S    = id;
        bus.ARADDR_S  = addr;
        bus.ARLEN_S   = LEN_BITS'(len);
        bus.ARBURST_S = burst;
        bus.ARSIZE_S  = 3'($urandom_range(0, 7));
        bus.ARVALID_S = 1'b1;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            if (bus.ARREADY_S) begin ok = 1; break; end
        end
        if (!ok) begin
            fails++; tests++;
            $display("FAIL ar_accept: ARREADY_S never rose for id %0h (got 0, need 1)", id);
        end
        @(posedge clock); #1;
        bus.ARVALID_S = 1'b0;
        bus.ARID_S    = ID_BITS'($urandom);
        bus.ARADDR_S  = $urandom;
        bus.ARLEN_S   = LEN_BITS'($urandom);
        bus.ARBURST_S = 2'($urandom);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (exp_q.size() == 0) begin ok = 1; break; end
        end
        if (!ok) begin
            fails++; tests++;
            $display("FAIL drain: %0d beats still outstanding (need 0)", exp_q.size());
        end
    endtask

    task automatic check_reset_state(input string name);
        logic [60:0] got, want;
        @(negedge clock);
        got  = {bus.ARREADY_S, bus.RVALID_S, bus.RLAST_S, bus.RRESP_S, bus.RID_S,
                bus.RDATA_S, mem_CS, mem_OE, mem_A};
        want = {1'b1, 60'd0};
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h, need %h", name, got, want);
        end
    endtask

    // RREADY driver: optional directed stall on one beat, otherwise always-ready or random.
    initial begin
        bus.RREADY_S = 1'b0;
        forever begin
            @(posedge clock); #1;
            if (stall_left > 0 && bus.RVALID_S && beats_done == stall_at) begin
                bus.RREADY_S = 1'b0;
                stall_left--;
            end else if (rand_ready) begin
                bus.RREADY_S = ($urandom_range(0, 2) != 0);
            end else begin
                bus.RREADY_S = 1'b1;
            end
        end
    end

    // Monitor / scoreboard.
    int ar_cyc = 0;
    bit first_pend = 0;
    bit chk_ar_next = 0;
    bit held_v = 0;
    beat_t held, cur, exp_b;
    always @(negedge clock) begin
        ncyc++;
        cur = {bus.RID_S, bus.RDATA_S, bus.RRESP_S, bus.RLAST_S};
        if (!reset) begin
            held_v = 0; first_pend = 0; chk_ar_next = 0;
        end else begin
            if (chk_ar_next) begin
                tests++;
                if (bus.ARREADY_S !== 1'b1) begin
                    fails++;
                    $display("FAIL arready_after_last: got %b, need 1", bus.ARREADY_S);
                end
                chk_ar_next = 0;
            end
            if (bus.ARVALID_S && bus.ARREADY_S) begin
                ar_cyc = ncyc;
                first_pend = 1;
            end
            if (bus.RVALID_S) begin
                tests++;
                if (bus.ARREADY_S !== 1'b0 || mem_CS !== 1'b0) begin
                    fails++;
                    $display("FAIL resp_ctrl: ARREADY_S=%b mem_CS=%b, need 0 and 0", bus.ARREADY_S, mem_CS);
                end
                if (first_pend) begin
                    tests++;
                    if (ncyc != ar_cyc + 2) begin
                        fails++;
                        $display("FAIL latency: first RVALID %0d cycles after AR, need 2", ncyc - ar_cyc);
                    end
                    first_pend = 0;
                end
                if (held_v) begin
                    tests++;
                    if (cur !== held) begin
                        fails++;
                        $display("FAIL stall_stable: got %h, need %h", cur, held);
                    end
                end
                if (bus.RREADY_S) begin
                    held_v = 0;
                    tests++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL beat: unexpected beat %h, none expected", cur);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (cur !== exp_b) begin
                            fails++;
                            $display("FAIL beat: got id=%h data=%h resp=%b last=%b, need id=%h data=%h resp=%b last=%b",
                                     cur.id, cur.data, cur.resp, cur.last,
                                     exp_b.id, exp_b.data, exp_b.resp, exp_b.last);
                        end
                    end
                    beats_done++;
                    if (bus.RLAST_S) chk_ar_next = 1;
                end else begin
                    held = cur;
                    held_v = 1;
                end
            end else begin
                held_v = 0;
                tests++;
                if (bus.RLAST_S !== 1'b0 || bus.RDATA_S !== '0 || bus.RRESP_S !== 2'b00) begin
                    fails++;
                    $display("FAIL r_idle: RLAST=%b RDATA=%h RRESP=%b, need 0/0/00",
                             bus.RLAST_S, bus.RDATA_S, bus.RRESP_S);
                end
            end
        end
    end

    initial begin
        #400000;
        if (!finished) begin
            fails++;
            $display("FAIL watchdog: simulation time limit reached");
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        int base;
        bit ok;
        bus.ARVALID_S = 1'b0;
        bus.ARID_S    = '0;
        bus.ARADDR_S  = '0;
        bus.ARLEN_S   = '0;
        bus.ARSIZE_S  = 3'd2;
        bus.ARBURST_S = 2'b01;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = (i * 32'h9E3779B9) ^ 32'h5A5A_0000;

        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        check_reset_state("reset_state");

        // Single read.
        mem[16'h10] = 32'hDEADBEEF;
        send_ar(8'h12, 32'h40, 0, 2'b01);
        wait_idle();

        // INCR burst with a 3-cycle stall on beat 2.
        mem[16'h40] = 32'd1; mem[16'h41] = 32'd2; mem[16'h42] = 32'd3; mem[16'h43] = 32'd4;
        stall_at = beats_done + 1;
        stall_left = 3;
        send_ar(8'h34, 32'h100, 3, 2'b01);
        wait_idle();

        // WRAP, FIXED, reserved, INCR wrap-around (upper address bits are don't-care).
        send_ar(8'h21, 32'h18, 3, 2'b10);
        send_ar(8'h22, 32'h24, 2, 2'b00);
        send_ar(8'h23, 32'h200, 1, 2'b11);
        send_ar(8'h24, {16'hA5C3, 14'h3FFF, 2'b11}, 1, 2'b01);
        wait_idle();

        // Reset during beat 2 of an 8-beat burst.
        base = beats_done;
        send_ar(8'h55, 32'h800, 7, 2'b01);
        ok = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (bus.RVALID_S && beats_done == base + 1) begin ok = 1; break; end
        end
        if (!ok) begin
            fails++; tests++;
            $display("FAIL reset_burst: beat 2 never presented (got %0d beats)", beats_done - base);
        end
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        exp_q.delete();
        check_reset_state("reset_mid_burst");
        send_ar(8'h56, 32'h300, 2, 2'b01);
        wait_idle();

        // Random back-to-back bursts with random RREADY.
        rand_ready = 1;
        for (int n = 0; n < 40; n++) begin
            send_ar(ID_BITS'($urandom), $urandom, int'($urandom_range(0, 15)), 2'($urandom));
        end
        wait_idle();
        repeat (4) @(negedge clock);

        finished = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
